// File: rtl/device_d_packer.sv
// Final stage of the A->B->C chain: buffers bytes from DeviceC in a small FIFO
// and packs groups of BYTES items into one word with an 8-bit modulo checksum.
module device_d_packer #(
    parameter int IN_W  = 8,
    parameter int BYTES = 4,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  readyC,
    input  logic [IN_W-1:0]       in_C,
    output logic                  acceptedD,
    output logic [IN_W*BYTES-1:0] out_D,
    output logic [7:0]            sum_D,
    output logic                  readyD,
    input  logic                  acceptedE,
    output logic [15:0]           word_cnt,
    output logic [0:0]            fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(BYTES);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    // Both handshakes: a transfer happens on every rising edge where the
    // valid side (readyC / readyD) and the accept side (acceptedD /
    // acceptedE) are high together. Valid holds its data until accepted.

    logic [IN_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [IW-1:0]   byte_idx;
    logic [0:0]      state;
    logic            push;
    logic            pop;
    logic [IN_W-1:0] item;
    logic [7:0]      item_lo;

    // Accept depends only on registered occupancy, never on readyC.
    assign acceptedD = !rst && (fifo_count != CW'(DEPTH));
    assign push      = readyC && acceptedD;
    assign pop       = (state == COLLECT) && (fifo_count != '0);
    assign item      = mem[rd_ptr];
    assign item_lo   = 8'(item);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            byte_idx <= '0;
            out_D    <= '0;
            sum_D    <= '0;
            readyD   <= 1'b0;
            word_cnt <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (pop) begin
                        out_D[byte_idx*IN_W +: IN_W] <= item;
                        // The first item of a word restarts the checksum.
                        if (byte_idx == '0) begin
                            sum_D <= item_lo;
                        end else begin
                            sum_D <= sum_D + item_lo;
                        end
                        if (byte_idx == IW'(BYTES - 1)) begin
                            byte_idx <= '0;
                            readyD   <= 1'b1;
                            state    <= PRESENT;
                        end else begin
                            byte_idx <= byte_idx + IW'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (acceptedE) begin
                        readyD   <= 1'b0;
                        word_cnt <= word_cnt + 16'd1;
                        byte_idx <= '0;
                        state    <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
